boot_copier: RTL and testbench

//  Wishbone master that copies the boot image from the boot ROM into RAM after reset,

---
 rtl/boot_copier_pkg.sv | 6 +
 rtl/wb_ack_timer.sv | 21 ++
 rtl/boot_copier.sv | 103 ++++++++++
 tb/tb_boot_copier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/boot_copier_pkg.sv
// boot_copier_pkg: shared state encoding and Wishbone constants for the boot copier.
package boot_copier_pkg;
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERROR} state_t;
    localparam logic [1:0] WB_SEL_WORD = 2'b11;
    localparam logic       WB_TGA_DATA = 1'b0;
endpackage

// File: rtl/wb_ack_timer.sv
// wb_ack_timer: counts strobe cycles without ack; expired flags the last allowed one.
module wb_ack_timer
    import boot_copier_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stb,
    input  logic ack,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // stb is always low for at least one cycle between strobes, so clearing while low
    // restarts the count on every rise
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) cnt <= '0;
        else          cnt <= stb ? cnt + CW'(!ack) : '0;
    assign expired = stb && !ack && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/boot_copier.sv
// boot_copier: Wishbone master copying LEN_WORDS words from boot ROM to RAM, holding the CPU meanwhile.
// Optional ack timeout enabled by defining BOOTCOPY_TIMEOUT_EN.
module boot_copier
    import boot_copier_pkg::*;
#(
    parameter logic [31:0] SRC_BASE       = 32'h0000_1000,
    parameter logic [31:0] DST_BASE       = 32'h0000_0000,
    parameter int          LEN_WORDS      = 640,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_hold_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_tga_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);
    localparam int CW = LEN_WORDS > 0 ? $clog2(LEN_WORDS + 1) : 1;
    state_t        state;
    logic [CW-1:0] n;
    logic          first, stb, timeout;
`ifdef BOOTCOPY_TIMEOUT_EN
    wb_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stb(stb), .ack(wb_ack_i), .expired(timeout)
    );
`else
    assign timeout = 1'b0 && TIMEOUT_CYCLES > 0;
`endif
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            state      <= IDLE;
            n          <= '0;
            first      <= 1'b1;
            stb        <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            cpu_hold_o <= 1'b1;
        end else begin
            first <= 1'b0;
            case (state)
                IDLE, DONE, ERROR:
                    if (start_i || (state == IDLE && AUTO_START && first)) begin
                        n          <= '0;
                        error_o    <= 1'b0;
                        done_o     <= LEN_WORDS == 0;
                        cpu_hold_o <= LEN_WORDS != 0;
                        busy_o     <= LEN_WORDS != 0;
                        state      <= LEN_WORDS == 0 ? DONE : READ;
                        stb        <= LEN_WORDS != 0;
                        wb_we_o    <= 1'b0;
                        wb_adr_o   <= SRC_BASE;
                    end
                READ, WRITE:
                    // stb low here is the mandatory idle cycle after an ack
                    if (!stb) begin
                        stb      <= 1'b1;
                        wb_we_o  <= state == WRITE;
                        wb_adr_o <= (state == WRITE ? DST_BASE : SRC_BASE) + (32'(n) << 2);
                    end else if (wb_ack_i) begin
                        stb     <= 1'b0;
                        wb_we_o <= 1'b0;
                        if (state == READ) begin
                            wb_dat_o <= wb_dat_i;
                            state    <= WRITE;
                        end else begin
                            n <= n + 1'b1;
                            if (n + 1'b1 == CW'(LEN_WORDS)) begin
                                state      <= DONE;
                                busy_o     <= 1'b0;
                                done_o     <= 1'b1;
                                cpu_hold_o <= 1'b0;
                            end else state <= READ;
                        end
                    end else if (timeout) begin
                        stb     <= 1'b0;
                        wb_we_o <= 1'b0;
                        state   <= ERROR;
                        busy_o  <= 1'b0;
                        error_o <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    assign wb_stb_o = stb;
    assign wb_cyc_o = stb;
    assign wb_sel_o = stb ? WB_SEL_WORD : 2'b00;
    assign wb_tga_o = WB_TGA_DATA;
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: self-checking bench; ROM/RAM slave models with programmable ack delay.
module tb_boot_copier;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, busy, done, error, hold, we, tga, stb, cyc, ack;
    logic [31:0] adr, dat_o, dat_i;
    logic [1:0]  sel;
    logic        s1_start, s1_busy, s1_done, s1_error, s1_hold, s1_we, s1_tga, s1_stb, s1_cyc;
    logic [31:0] s1_adr, s1_dat_o;
    logic [1:0]  s1_sel;

    int checks = 0, fails = 0;
    int rd_dly = 0, wr_dly = 0, wcnt = 0;
    bit stall = 0;
    logic [31:0] rom [4];
    logic [63:0] wlog [256];
    int n_rd = 0, n_wr = 0, gap_err = 0, stab_err = 0, bus_err = 0, hold_err = 0;
    int stb_cyc = 0, s1_stb_cyc = 0;
    logic p_stb = 0, p_ack = 0, p_we = 0;
    logic [31:0] p_adr = 0, p_dat = 0;

    boot_copier #(.LEN_WORDS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .error_o(error), .cpu_hold_o(hold), .wb_adr_o(adr), .wb_dat_o(dat_o),
        .wb_dat_i(dat_i), .wb_we_o(we), .wb_sel_o(sel), .wb_tga_o(tga),
        .wb_stb_o(stb), .wb_cyc_o(cyc), .wb_ack_i(ack)
    );
    boot_copier #(.LEN_WORDS(0), .AUTO_START(1'b0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(s1_start), .busy_o(s1_busy), .done_o(s1_done),
        .error_o(s1_error), .cpu_hold_o(s1_hold), .wb_adr_o(s1_adr), .wb_dat_o(s1_dat_o),
        .wb_dat_i(32'h0), .wb_we_o(s1_we), .wb_sel_o(s1_sel), .wb_tga_o(s1_tga),
        .wb_stb_o(s1_stb), .wb_cyc_o(s1_cyc), .wb_ack_i(s1_stb & s1_cyc)
    );

    // Slave: ack after the programmed number of wait cycles; ROM occupies 0x1000..0x100F
    assign ack   = stb && cyc && !stall && wcnt >= (we ? wr_dly : rd_dly);
    assign dat_i = (adr >= 32'h1000 && adr < 32'h1010) ? rom[adr[3:2]] : 32'hBAD0_0BAD;
    always @(posedge clk) wcnt <= (stb && !ack) ? wcnt + 1 : 0;

    always @(negedge clk)
        if (rst_n) begin
            if (p_ack && stb) gap_err <= gap_err + 1;
            if (p_stb && !p_ack && stb && (adr != p_adr || dat_o != p_dat || we != p_we))
                stab_err <= stab_err + 1;
            if (cyc != stb || sel != (stb ? 2'b11 : 2'b00) || tga || adr[1:0] != 2'b00)
                bus_err <= bus_err + 1;
            if (busy && !hold) hold_err <= hold_err + 1;
            if (stb) stb_cyc <= stb_cyc + 1;
            if (s1_stb || s1_cyc || s1_busy) s1_stb_cyc <= s1_stb_cyc + 1;
            if (stb && ack && we) begin
                wlog[n_wr % 256] <= {adr, dat_o};
                n_wr <= n_wr + 1;
            end
            if (stb && ack && !we) n_rd <= n_rd + 1;
            p_stb <= stb; p_ack <= ack; p_we <= we; p_adr <= adr; p_dat <= dat_o;
        end else begin
            p_stb <= 1'b0;
            p_ack <= 1'b0;
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic new_image();
        for (int i = 0; i < 4; i++) rom[i] = $urandom;
    endtask

    // Expected RAM image: word i of ROM lands at byte address 4*i, in order, exactly once
    task automatic chk_copy(input string nm, input int wbase, input int rbase);
        chk({nm, "_writes"}, 64'(n_wr - wbase), 64'd4);
        chk({nm, "_reads"}, 64'(n_rd - rbase), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_word%0d", nm, i), wlog[(wbase + i) % 256], {32'(4 * i), rom[i]});
    endtask

    task automatic run_copy(input bit go, input bit mid, output int edges, output logic hb);
        edges = 0;
        hb    = hold;
        start = go;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            edges++;
            #1;
            start = mid && edges == 5;
            if (done) break;
            hb = hold;
        end
        start = 1'b0;
    endtask

    typedef struct {int rd; int wr; bit mid; int exp_clk;} vec_t;
    vec_t tv[6];

    initial begin
        int edges, wb, rb, sc, viol;
        logic hb;
        rst_n = 1'b0; start = 1'b0; s1_start = 1'b0;
        new_image();
        #12;
        chk("reset_hold", hold, 1);
        chk("reset_bus", {stb, cyc, we, sel}, 0);
        chk("reset_flags", {busy, done, error}, 0);
        chk("reset_adr_dat", {adr, dat_o}, 0);
        @(negedge clk) rst_n = 1'b1;
        wb = n_wr; rb = n_rd;
        run_copy(1'b0, 1'b0, edges, hb);
        chk("auto_done_clk", edges, 16);
        chk("auto_hold_edge", {hb, hold, done}, 3'b101);
        chk_copy("auto", wb, rb);

        chk("len0_idle", {s1_done, s1_hold}, 2'b01);
        s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        chk("len0_done", {s1_done, s1_hold, s1_busy}, 3'b100);

        tv[0] = '{0, 0, 1'b0, 0};
        tv[1] = '{0, 3, 1'b0, 0};
        tv[2] = '{2, 1, 1'b1, 0};
        tv[3] = '{3, 0, 1'b0, 0};
        for (int i = 4; i < 6; i++) tv[i] = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), 0};
        foreach (tv[i]) tv[i].exp_clk = 4 * (4 + tv[i].rd + tv[i].wr);
        foreach (tv[i]) begin
            rd_dly = tv[i].rd; wr_dly = tv[i].wr;
            new_image();
            wb = n_wr; rb = n_rd;
            run_copy(1'b1, tv[i].mid, edges, hb);
            chk($sformatf("vec%0d_done_clk", i), edges, tv[i].exp_clk);
            chk_copy($sformatf("vec%0d", i), wb, rb);
        end

        rd_dly = 0; wr_dly = 0;
        new_image();
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (stb && we && adr == 32'h8) break;
        end
        chk("rst_mid_setup", {stb, we, adr}, {2'b11, 32'h8});
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_async", {stb, cyc, busy, hold}, 4'b0001);
        @(negedge clk) rst_n = 1'b1;
        wb = n_wr; rb = n_rd;
        run_copy(1'b0, 1'b0, edges, hb);
        chk("rst_recopy_clk", edges, 16);
        chk_copy("rst_recopy", wb, rb);

        stall = 1'b1;
        sc = stb_cyc;
        wb = n_wr; rb = n_rd;
        start = 1'b1;
`ifdef BOOTCOPY_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (error) break;
        end
        chk("tmo_state", {error, stb, cyc, busy, hold, done}, 6'b100010);
        chk("tmo_stb_cycles", 64'(stb_cyc - sc), 64'd8);
        stall = 1'b0;
        wb = n_wr; rb = n_rd;
        run_copy(1'b1, 1'b0, edges, hb);
        chk("tmo_retry_clk", edges, 16);
        chk("tmo_retry_flags", {error, done, hold}, 3'b010);
        chk_copy("tmo_retry", wb, rb);
`else
        viol = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (!stb || error || !hold) viol++;
        end
        chk("stall_forever", viol, 0);
        stall = 1'b0;
        run_copy(1'b0, 1'b0, edges, hb);
        chk("stall_resume", {done, error, hold}, 3'b100);
        chk_copy("stall", wb, rb);
`endif

        chk("no_stb_after_ack", gap_err, 0);
        chk("stable_while_stb", stab_err, 0);
        chk("bus_signals", bus_err, 0);
        chk("hold_while_busy", hold_err, 0);
        chk("len0_never_busy", s1_stb_cyc, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
